// File: rtl/sr_pkg.sv
// Shared types and constants for the SR request conditioner.
package sr_pkg;

  localparam int DB_CYCLES_DEF = 4;
  localparam int DB_CNT_W      = $clog2(256);

  typedef enum logic [1:0] {ARB_NONE, ARB_SET, ARB_CLR, ARB_BOTH} arb_t;

  function automatic arb_t arb_decode(input logic set_evt, input logic clr_evt);
    arb_t a;
    case ({set_evt, clr_evt})
      2'b10:   a = ARB_SET;
      2'b01:   a = ARB_CLR;
      2'b11:   a = ARB_BOTH;
      default: a = ARB_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchroniser, stability debounce and a
// registered rising-edge event on the accepted level.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise_evt
);

  logic                sync1;
  logic                sync2;
  logic                lvl;
  logic [DB_CNT_W-1:0] cnt;

  // lvl only moves after DB_CYCLES consecutive samples that disagree with it;
  // rise_evt is set on the same edge that lvl goes 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      lvl      <= 1'b0;
      cnt      <= '0;
      rise_evt <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      rise_evt <= 1'b0;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
        lvl      <= sync2;
        cnt      <= '0;
        rise_evt <= sync2;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sr_req_conditioner.sv
// Conditions raw set/clear requests into exclusive one-cycle s/r pulses.
// Build option SR_TOGGLE_EN: simultaneous requests toggle q (JK style)
// instead of letting clear dominate.
module sr_req_conditioner
  import sr_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_raw,
  input  logic             clr_raw,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             conflict,
  output logic [CNT_W-1:0] pulse_cnt
);

  logic set_evt;
  logic clr_evt;
  arb_t arb;
  logic s_nxt;
  logic r_nxt;
  logic conflict_nxt;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk      (clk),
    .rst      (rst),
    .raw      (set_raw),
    .rise_evt (set_evt)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk      (clk),
    .rst      (rst),
    .raw      (clr_raw),
    .rise_evt (clr_evt)
  );

  assign arb = arb_decode(set_evt, clr_evt);

`ifndef SR_TOGGLE_EN
  // q feedback only matters when toggling.
  logic q_fb_unused;
  assign q_fb_unused = q_fb;
`endif

  always_comb begin
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    conflict_nxt = 1'b0;
    case (arb)
      ARB_SET: s_nxt = 1'b1;
      ARB_CLR: r_nxt = 1'b1;
      ARB_BOTH: begin
        conflict_nxt = 1'b1;
`ifdef SR_TOGGLE_EN
        s_nxt = ~q_fb;
        r_nxt = q_fb;
`else
        r_nxt = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= 1'b0;
      r         <= 1'b0;
      conflict  <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      s         <= s_nxt;
      r         <= r_nxt;
      conflict  <= conflict_nxt;
      pulse_cnt <= pulse_cnt + CNT_W'(s | r);
    end
  end

endmodule

// File: tb/tb_sr_req_conditioner.sv
// Self-checking bench for sr_req_conditioner (DB_CYCLES=4, CNT_W=8).
module tb_sr_req_conditioner;

  localparam int W = 35; // {cycle[31:0], s, r, conflict}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_raw = 1'b0;
  logic       clr_raw = 1'b0;
  logic       q_fb = 1'b0;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] pulse_cnt;

  int unsigned cyc = 0;
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct {
    int   set_len;
    int   clr_len;
    logic qfb;
    logic es;
    logic er;
    logic ec;
  } vec_t;

  vec_t vecs[10];

  sr_req_conditioner #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_raw   (set_raw),
    .clr_raw   (clr_raw),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .conflict  (conflict),
    .pulse_cnt (pulse_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout actual=still_running required=finished");
    $fatal(1, "timeout");
  end

  // scoreboard: every cycle with s|r|conflict must match the queue head in time and value
  always @(negedge clk) begin
    logic [W-1:0] head;
    if (!rst) begin
      checks++;
      if (s && r) begin
        errors++;
        $display("FAIL s_r_exclusive cycle=%0d actual s=%0b r=%0b required not both", cyc, s, r);
      end
      while (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[W-1:3] >= cyc) break;
        checks++;
        errors++;
        $display("FAIL missing_pulse cycle=%0d actual none required s/r/c=%03b", head[W-1:3], head[2:0]);
        void'(exp_q.pop_front());
      end
      if (s | r | conflict) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cycle=%0d actual s/r/c=%b%b%b required none", cyc, s, r, conflict);
        end else begin
          head = exp_q[0];
          if (head[W-1:3] != cyc) begin
            errors++;
            $display("FAIL early_pulse cycle=%0d actual s/r/c=%b%b%b required at cycle %0d", cyc, s, r, conflict, head[W-1:3]);
          end else begin
            void'(exp_q.pop_front());
            if ({s, r, conflict} != head[2:0]) begin
              errors++;
              $display("FAIL pulse_value cycle=%0d actual s/r/c=%b%b%b required %03b", cyc, s, r, conflict, head[2:0]);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // driver: called at a negedge; edge 1 is the next posedge, pulse expected after edge 7
  task automatic press(input int sl, input int cl, input logic qfb,
                       input logic es, input logic er, input logic ec);
    int n;
    n = (sl > cl) ? sl : cl;
    q_fb = qfb;
    if (es | er | ec) begin
      exp_q.push_back({32'(cyc + 7), es, er, ec});
      if (es | er) exp_cnt = (exp_cnt + 1) % 256;
    end
    for (int i = 0; i < n; i++) begin
      set_raw = (i < sl);
      clr_raw = (i < cl);
      @(negedge clk);
    end
    set_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_s"}, int'(s), 0);
    chk({tag, "_r"}, int'(r), 0);
    chk({tag, "_conflict"}, int'(conflict), 0);
    chk({tag, "_pulse_cnt"}, int'(pulse_cnt), 0);
    exp_q.delete();
    exp_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic both_s;
    logic both_r;
    int   n;

    // {set_len, clr_len, q_fb, exp_s, exp_r, exp_conflict}
    vecs[0] = '{20, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{0, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{6, 6, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SR_TOGGLE_EN
    both_s = 1'b1; both_r = 1'b0;
`else
    both_s = 1'b0; both_r = 1'b1;
`endif
    vecs[4] = '{6, 6, 1'b0, both_s, both_r, 1'b1};
    vecs[5] = '{2, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{5, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{3, 10, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8, 8, 1'b1, 1'b0, 1'b1, 1'b1};

    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].set_len, vecs[i].clr_len, vecs[i].qfb, vecs[i].es, vecs[i].er, vecs[i].ec);
      chk($sformatf("vec%0d_pulse_cnt", i), int'(pulse_cnt), exp_cnt);
    end

    // reset on edge 4 of a held set request; one pulse 7 edges after release
    q_fb = 1'($urandom_range(0, 1));
    set_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pulse_cnt_cleared", int'(pulse_cnt), 0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back({32'(cyc + 7), 3'b100});
    exp_cnt = 1;
    repeat (16) @(negedge clk);
    set_raw = 1'b0;
    repeat (14) @(negedge clk);
    chk("midrst_pulse_cnt", int'(pulse_cnt), exp_cnt);

    // counter wrap with alternating presses
    do_reset("wrap_reset");
    for (int k = 0; k < 256; k++) begin
      n = $urandom_range(4, 8);
      if (k % 2 == 0) press(n, 0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      else            press(0, n, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      if (k == 254) chk("wrap_pulse_cnt_255", int'(pulse_cnt), 255);
    end
    chk("wrap_pulse_cnt_0", int'(pulse_cnt), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_req_conditioner.md
Name: sr_req_conditioner

Overview:
- Upstream front end for the SR flip-flop stage.
- Takes two raw, asynchronous request lines (set and clear), then synchronises, debounces and edge-detects them.
- Emits clean one-cycle s/r pulses that are never high together, with a defined resolution when both requests arrive in the same cycle.
- Reads the flip-flop's q back so simultaneous requests can be resolved with JK-style toggle semantics.

Parameters:
- DB_CYCLES, 4: consecutive stable samples needed to accept a level change. Legal range 2..255.
- CNT_W, 8: width of pulse_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- set_raw  input  1  raw set request, asynchronous to clk.
- clr_raw  input  1  raw clear request, asynchronous to clk.
- q_fb  input  1  current q of the downstream SR flip-flop.
- s  output  1  one-cycle set pulse to the flip-flop.
- r  output  1  one-cycle reset pulse to the flip-flop.
- conflict  output  1  one-cycle flag: both requests were accepted in the same cycle.
- pulse_cnt  output  CNT_W  running count of emitted s or r pulses.

Behaviour:
- Reset: one clock, rst=1 on a rising edge. The reset is synchronous and active-high.
  - After it: s=0, r=0, conflict=0, pulse_cnt=0.
  - All synchroniser flops, debounce levels and counters are 0.
- Synchroniser: two flops per raw input.
- Debounce, per channel. State is an accepted level lvl and a counter cnt.
  - If the synchronised input equals lvl: cnt<=0.
  - Otherwise cnt increments. When it reaches DB_CYCLES-1 while the input still differs: lvl<=input, cnt<=0.
  - Any glitch shorter than DB_CYCLES samples is rejected.
- Event: rise_evt is registered with lvl and is high for exactly the one cycle where lvl goes 0->1. Falling edges produce no event.
- Arbitration is registered, one stage after rise_evt:
  - set only: s=1, r=0.
  - clear only: s=0, r=1.
  - neither: s=0, r=0.
  - both: conflict=1; s and r are resolved per the Optional Feature section.
- Latency: edge 1 is the first clk edge sampling the new raw level, held stable. rise_evt is high after edge DB_CYCLES+2; s or r is high after edge DB_CYCLES+3 for one cycle.
- Invariant: s and r are never 1 in the same cycle.
- pulse_cnt increments by 1 on each cycle with s|r=1 and wraps from 2^CNT_W-1 to 0.
- Held input: a request held high for any length produces exactly one pulse. Release, then a re-press of at least DB_CYCLES cycles, is needed for the next pulse.
- Reset mid-debounce discards the partial count.
- Raw input high across reset release: lvl restarts at 0, so one pulse is emitted DB_CYCLES+3 edges after release.
- q_fb is sampled in the arbitration cycle only.

Optional Feature:
- Macro: SR_TOGGLE_EN.
- Defined: simultaneous set and clear act as a JK toggle. s=~q_fb and r=q_fb for one cycle, and conflict=1.
- Undefined: clear dominates. s=0, r=1, conflict=1.
- pulse_cnt increments in both cases.

Decomposition:
- Shared package sr_pkg holds:
  - DB_CYCLES_DEF=4.
  - localparam DB_CNT_W=$clog2(256).
  - enum arb_t {ARB_NONE, ARB_SET, ARB_CLR, ARB_BOTH} used by the arbitration logic.
- One natural sub-module, sr_debounce: synchroniser, debounce counter and rise_evt for a single channel. It is instantiated twice. The top holds arbitration, conflict and pulse_cnt.

Test Plan:
All scenarios use DB_CYCLES=4.
- Reset behaviour: rst=1 for 2 cycles with set_raw=clr_raw=0 -> s=r=conflict=0, pulse_cnt=0.
- Basic set pulse: set_raw 0->1 held 20 cycles -> s=1 for exactly one cycle after edge 7; r=0; pulse_cnt=1; no further pulses while held.
- Glitch rejection: clr_raw high for 3 cycles then low -> no r pulse, pulse_cnt unchanged.
  - Then clr_raw high for 4 cycles -> exactly one r pulse.
- Simultaneous requests: set_raw and clr_raw rise on the same edge with q_fb=1.
  - Macro undefined -> r=1, s=0, conflict=1.
  - Macro defined -> r=1, s=0; repeat with q_fb=0 -> s=1, r=0, conflict=1.
- Reset mid-operation: set_raw rises, rst asserted on edge 4 for 1 cycle, set_raw kept high -> no pulse before release; one s pulse 7 edges after release.
- Counter wrap: 256 alternating set/clear presses -> pulse_cnt reads 255 then wraps to 0; s and r never high together throughout.
